data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 64-bit storage words (power of 2, at least 2).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of cycles from request accept to response valid (1..15).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port req_valid  input  1  meaning the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  meaning the responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  meaning 1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  64  meaning the byte address.
REQ-009 SHALL have port req_wdata  input  64  meaning store data, right-aligned (bits [8*N-1:0] used).
REQ-010 SHALL have port req_size  input  2  meaning the access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-011 SHALL have port req_unsigned  input  1  meaning zero-extend load data; ignored for size 3 and for stores.
REQ-012 SHALL have port resp_valid  output  1  meaning a response is presented.
REQ-013 SHALL have port resp_ready  input  1  meaning the initiator takes the response.
REQ-014 SHALL have port resp_rdata  output  64  meaning the extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  meaning the request was misaligned or out of range.

Function
REQ-016 SHALL implement an FSM with states IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, register all request fields, and move IDLE->BUSY with a latency counter loaded with LATENCY-1.
REQ-018 SHALL, in BUSY, decrement the counter each cycle and move BUSY->RESP on the edge where the counter is 0, so that resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-019 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until an edge with resp_ready=1, then move RESP->IDLE; no new request SHALL be accepted on that same edge.
REQ-020 SHALL treat the address as little-endian: word index = req_addr[log2(DEPTH_WORDS)+2:3], byte lane = req_addr[2:0].
REQ-021 SHALL flag misalignment when: size 1 and addr[0]!=0; size 2 and addr[1:0]!=0; size 3 and addr[2:0]!=0.
REQ-022 SHALL flag out-of-range when req_addr >= DEPTH_WORDS*8, comparing the full 64 bits.
REQ-023 SHALL, for a flagged request, respond with resp_err=1 and resp_rdata=0, and SHALL leave memory unchanged.
REQ-024 SHALL commit a store on the BUSY->RESP edge, updating only the 1, 2, 4 or 8 lanes selected by size and byte lane.
REQ-025 SHALL, for a load, read the word on the BUSY->RESP edge, shift the selected lanes to bit 0, and sign-extend (or zero-extend if req_unsigned=1) from bit 8*N-1.
REQ-026 SHALL ignore req_valid outside IDLE; the initiator SHALL hold the request until it is accepted.

Reset
REQ-027 SHALL, while reset=0, force the state to IDLE, the counter to 0, req_ready=0, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-028 SHALL drive req_ready=1 from the first cycle after reset deasserts.
REQ-029 SHALL drop a pending request when reset asserts in BUSY or RESP; a store not yet committed SHALL NOT modify memory.
REQ-030 SHALL NOT clear memory contents on reset.

Verification
REQ-031 Scenario: store size 3, addr 0x10, data 0x1122334455667788, then load size 3 from 0x10 -> load response 0x1122334455667788, resp_err=0; resp_valid rises exactly 2 cycles after each accept.
REQ-032 Scenario: following REQ-031, load size 0 from 0x17 signed -> 0x0000000000000011; load size 1 from 0x10 signed after a store of byte 0xF0 to 0x11 -> 0xFFFFFFFFFFFFF088; the same load with req_unsigned=1 -> 0x000000000000F088.
REQ-033 Scenario: store size 2 at 0x12 -> resp_err=1 and resp_rdata=0; a follow-up load size 3 from 0x10 is unchanged. Load at 0x800 (DEPTH_WORDS=256) -> resp_err=1.
REQ-034 Scenario: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata are stable and req_ready=0 throughout; a req_valid pulse during that time is never accepted.
REQ-035 Scenario: accept a store to 0x20 of 0xAA, then assert reset one cycle later while in BUSY -> outputs go to 0 immediately (asynchronously); after release, a load from 0x20 returns the prior contents.
REQ-036 Scenario: rerun REQ-031 with LATENCY=1 and LATENCY=4 -> resp_valid rises exactly 1 and 4 cycles after accept respectively.

Source files
------------

// File: rtl/data_mem_responder.sv
// Latency-configurable 64-bit data memory responder with valid/ready handshakes.
// Requests are checked for alignment and range; loads are little-endian and sign- or zero-extended.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state, state_next;
  logic [3:0]       cnt;
  logic             write_q, unsigned_q, err_q;
  logic [1:0]       size_q;
  logic [2:0]       lane_q;
  logic [IDX_W-1:0] idx_q;
  logic [63:0]      wdata_q;
  logic [63:0]      mem [DEPTH_WORDS];

  logic        accept, complete, misaligned, req_err;
  logic [7:0]  base_en, byte_en;
  logic [63:0] bit_mask, wdata_shifted, word, merged, shifted, load_data;

  // Request qualification: alignment by size, full 64-bit range compare.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
    req_err = misaligned || (req_addr >= ADDR_LIMIT);
  end

  // Handshake and next-state logic; req_ready is gated by reset so it reads 0 while held in reset.
  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE) && reset;
    resp_valid = (state == RESP);
    accept     = req_valid && req_ready;
    complete   = (state == BUSY) && (cnt == '0);
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (cnt == '0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Lane selection, store merge and load extension on the registered request.
  always_comb begin
    case (size_q)
      2'd0:    base_en = 8'h01;
      2'd1:    base_en = 8'h03;
      2'd2:    base_en = 8'h0F;
      default: base_en = 8'hFF;
    endcase
    byte_en  = base_en << lane_q;
    bit_mask = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      bit_mask[8*b +: 8] = {8{byte_en[b]}};
    end
    wdata_shifted = wdata_q << {lane_q, 3'b000};
    word          = mem[idx_q];
    merged        = (word & ~bit_mask) | (wdata_shifted & bit_mask);
    shifted       = word >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    load_data = {{56{shifted[7]  & ~unsigned_q}}, shifted[7:0]};
      2'd1:    load_data = {{48{shifted[15] & ~unsigned_q}}, shifted[15:0]};
      2'd2:    load_data = {{32{shifted[31] & ~unsigned_q}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      lane_q     <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt        <= CNT_LOAD;
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        err_q      <= req_err;
        size_q     <= req_size;
        lane_q     <= req_addr[2:0];
        idx_q      <= req_addr[IDX_W+2:3];
        wdata_q    <= req_wdata;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
      if (complete) begin
        resp_err   <= err_q;
        resp_rdata <= (write_q || err_q) ? '0 : load_data;
      end else if ((state == RESP) && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // Storage is never reset; the commit only fires from BUSY, which reset leaves immediately.
  always_ff @(posedge clk) begin
    if (complete && write_q && !err_q) mem[idx_q] <= merged;
  end

endmodule
